// File: rtl/bus_register.sv
// -----------------------------------------------------------------------------
// bus_register
//
// General-purpose data register for the 16-bit CPU datapath. One instance per
// architectural register (R0..R7, A, G). On a rising clock edge with r_in high
// it captures the shared data bus (buswires). With r_in low it holds. The
// stored value is driven straight from the flops onto r_out, toward the bus
// multiplexer and the ALU.
//
// Parameters:
//   WIDTH        data width of buswires / r_out (legal range 1..64)
//   RESET_VALUE  value held while rst_n is low
//
// Ports:
//   clk       in   1      system clock, rising edge active
//   rst_n     in   1      asynchronous active-low reset
//   r_in      in   1      load enable, sampled on the rising edge
//   buswires  in   WIDTH  data bus value to capture
//   r_out     out  WIDTH  stored value (registered, no input-to-output path)
//
// Optional feature, macro BUS_REGISTER_PARITY_EN:
//   par_chk   in   1      externally supplied parity to compare against
//   par_out   out  1      registered even parity (XOR of all bits) of r_out
//   par_err   out  1      par_chk XOR par_out (combinational)
// Without the macro the port list is exactly the five ports above.
// -----------------------------------------------------------------------------
module bus_register #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r_in,
  input  logic [WIDTH-1:0] buswires,
`ifdef BUS_REGISTER_PARITY_EN
  input  logic             par_chk,
  output logic             par_out,
  output logic             par_err,
`endif
  output logic [WIDTH-1:0] r_out
);

  // Reject illegal widths at elaboration rather than building something odd.
  generate
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("bus_register: WIDTH must be in 1..64");
    end
  endgenerate

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next state: take the bus on a load, otherwise hold. X/Z on the bus is
  // passed through unchanged when loaded.
  always_comb begin
    data_d = data_q;
    if (r_in) begin
      data_d = buswires;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign r_out = data_q;

`ifdef BUS_REGISTER_PARITY_EN
  // The parity bit is computed from the bus at the load edge, so it updates
  // in the same cycle as r_out rather than trailing it by a reduction delay.
  localparam logic RESET_PARITY = ^RESET_VALUE;

  logic par_q;
  logic par_d;

  always_comb begin
    par_d = par_q;
    if (r_in) begin
      par_d = ^buswires;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= RESET_PARITY;
    end else begin
      par_q <= par_d;
    end
  end

  assign par_out = par_q;
  assign par_err = par_chk ^ par_q;
`endif

endmodule

// File: tb/tb_bus_register.sv
`timescale 1ns/1ps
module tb_bus_register;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         r_in;
  logic [W-1:0] buswires;
  logic [W-1:0] r_out;
`ifdef BUS_REGISTER_PARITY_EN
  logic         par_chk;
  logic         par_out;
  logic         par_err;
`endif

  bus_register #(.WIDTH(W), .RESET_VALUE('0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .r_in     (r_in),
    .buswires (buswires),
`ifdef BUS_REGISTER_PARITY_EN
    .par_chk  (par_chk),
    .par_out  (par_out),
    .par_err  (par_err),
`endif
    .r_out    (r_out)
  );

  // Rising edges at 10, 20, ... ns (so 110 ns is an active edge).
  initial clk = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string        name;
    logic         r_in;
    logic [W-1:0] bus;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] sb_q[$];   // scoreboard of expected r_out values

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: r_out=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s: r_out=%h", name, act);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  // Drive on the falling edge, push the expected value, then compare 1 ns
  // after the following rising edge.
  task automatic step(input string name, input logic ri, input logic [W-1:0] bus,
                      input logic [W-1:0] exp);
    logic [W-1:0] e;
    @(negedge clk);
    r_in     = ri;
    buswires = bus;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, r_out=%h", name, r_out);
    end else begin
      e = sb_q.pop_front();
      check(name, r_out, e);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    r_in     = 1'b1;
    buswires = 16'hFFFF;
`ifdef BUS_REGISTER_PARITY_EN
    par_chk  = 1'b0;
`endif

    // Reset held with load requested and bus all ones: must stay cleared.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset_hold_%0d", i), r_out, 16'h0000);
    end
`ifdef BUS_REGISTER_PARITY_EN
    check_bit("reset_par_out", par_out, 1'b0);
`endif

    @(negedge clk);
    r_in     = 1'b0;
    buswires = 16'h0000;
    rst_n    = 1'b1;

    // Vector table: idle hold, single load, ignored bus changes, back-to-back.
    for (int i = 0; i < 5; i++)
      vecs.push_back('{$sformatf("idle_%0d", i), 1'b0, 16'h0000, 16'h0000});
    vecs.push_back('{"load_abcd", 1'b1, 16'hABCD, 16'hABCD});
    for (int i = 0; i < 3; i++)
      vecs.push_back('{$sformatf("hold_abcd_%0d", i), 1'b0, 16'h1234, 16'hABCD});
    vecs.push_back('{"b2b_0001", 1'b1, 16'h0001, 16'h0001});
    vecs.push_back('{"b2b_8000", 1'b1, 16'h8000, 16'h8000});
    vecs.push_back('{"b2b_5a5a", 1'b1, 16'h5A5A, 16'h5A5A});

    foreach (vecs[i]) step(vecs[i].name, vecs[i].r_in, vecs[i].bus, vecs[i].exp);

    // Between-edge glitch on r_in/buswires must not be captured.
    @(negedge clk);
    r_in = 1'b0;
    #1 r_in = 1'b1; buswires = 16'hDEAD;
    #1 r_in = 1'b0; buswires = 16'h0000;
    @(posedge clk);
    #1;
    check("glitch_ignored", r_out, 16'h5A5A);

    // Asynchronous reset pulse between edges: clears with no clock edge.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset_now", r_out, 16'h0000);
    #2 rst_n = 1'b1;
    step("load_after_reset", 1'b1, 16'h00FF, 16'h00FF);

`ifdef BUS_REGISTER_PARITY_EN
    step("par_load_abcd", 1'b1, 16'hABCD, 16'hABCD);
    par_chk = 1'b1;
    #1;
    check_bit("par_out_abcd", par_out, 1'b0);
    check_bit("par_err_abcd", par_err, 1'b1);
    step("par_load_0001", 1'b1, 16'h0001, 16'h0001);
    #1;
    check_bit("par_out_0001", par_out, 1'b1);
    check_bit("par_err_0001", par_err, 1'b0);
    step("par_hold", 1'b0, 16'h0003, 16'h0001);
    check_bit("par_out_hold", par_out, 1'b1);
`endif

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 ns");
    $fatal(1, "timeout");
  end

endmodule
